// File: rtl/universal_shift_reg_burst.sv
// WIDTH-bit universal shift register with single-step modes
// and a counted burst engine (busy/done handshake).
module universal_shift_reg_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             shiftleft,
   input  logic             shiftright,
   input  logic [WIDTH-1:0] parallelin,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] q,
   output logic             serout_l,
   output logic             serout_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [2:0]       bmode;
   logic [CNT_W-1:0] rem;
   logic             accept;

   function automatic logic [WIDTH-1:0] step(
      input logic [2:0]       m,
      input logic [WIDTH-1:0] v,
      input logic             sl,
      input logic             sr,
      input logic [WIDTH-1:0] pin
   );
      logic [WIDTH-1:0] r;
      r = v;
      case (m)
         3'b001:  r = {v[WIDTH-2:0], sl};
         3'b010:  r = {sr, v[WIDTH-1:1]};
         3'b011:  r = pin;
         3'b100:  r = {v[WIDTH-2:0], v[WIDTH-1]};
         3'b101:  r = {v[0], v[WIDTH-1:1]};
         3'b110:  r = {v[WIDTH-1], v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   // Only shift/rotate modes make sense as a burst.
   assign accept = start && (count != '0) &&
                   (mode inside {3'b001, 3'b010, 3'b100,
                                 3'b101, 3'b110});

   assign serout_l = q[WIDTH-1];
   assign serout_r = q[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         bmode <= 3'b000;
         rem   <= '0;
      end else begin
         case (state)
            RUN: begin
               q   <= step(bmode, q, shiftleft,
                           shiftright, parallelin);
               rem <= rem - CNT_W'(1);
               if (rem == CNT_W'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               done <= 1'b0;
               if (accept) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  bmode <= mode;
                  rem   <= count;
               end else begin
                  state <= IDLE;
                  if (en)
                     q <= step(mode, q, shiftleft,
                               shiftright, parallelin);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_universal_shift_reg_burst.sv
// Scoreboard bench for universal_shift_reg_burst:
// directed plan sequences then randomized traffic.
module tb_universal_shift_reg_burst;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, en, shiftleft, shiftright, start;
   logic [2:0]    mode;
   logic [W-1:0]  parallelin;
   logic [CW-1:0] count;
   logic [W-1:0]  q;
   logic          serout_l, serout_r, busy, done;

   universal_shift_reg_burst #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .shiftleft(shiftleft), .shiftright(shiftright),
      .parallelin(parallelin), .start(start), .count(count),
      .q(q), .serout_l(serout_l), .serout_r(serout_r),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t eq[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: plain integers, no state encoding.
   logic [W-1:0] m_q = '0;
   int           m_left = 0;
   logic [2:0]   m_bmode = 3'b000;
   logic         m_done = 1'b0;

   function automatic logic [W-1:0] ref_op(
      input logic [2:0] m, input logic [W-1:0] v,
      input logic sl, input logic sr, input logic [W-1:0] p);
      logic [W-1:0] r;
      case (m)
         3'd1: r = W'((v << 1) | W'(sl));
         3'd2: r = W'((v >> 1) | (W'(sr) << (W - 1)));
         3'd3: r = p;
         3'd4: r = W'((v << 1) | (v >> (W - 1)));
         3'd5: r = W'((v >> 1) | (v << (W - 1)));
         3'd6: r = W'($signed(v) >>> 1);
         default: r = v;
      endcase
      return r;
   endfunction

   task automatic cyc(input logic r, input logic e,
                      input logic [2:0] m, input logic sl,
                      input logic sr, input logic [W-1:0] p,
                      input logic s, input logic [CW-1:0] c);
      exp_t x;
      rst = r; en = e; mode = m; shiftleft = sl;
      shiftright = sr; parallelin = p; start = s; count = c;
      if (r) begin
         m_q = '0; m_left = 0; m_bmode = 3'b000; m_done = 1'b0;
      end else if (m_left > 0) begin
         m_q = ref_op(m_bmode, m_q, sl, sr, p);
         m_left--;
         m_done = (m_left == 0);
      end else begin
         m_done = 1'b0;
         if (s && c != 0 && m inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) begin
            m_left = int'(c);
            m_bmode = m;
         end else if (e) begin
            m_q = ref_op(m, m_q, sl, sr, p);
         end
      end
      x.q = m_q; x.busy = (m_left > 0); x.done = m_done;
      @(posedge clk);
      eq.push_back(x);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (eq.size() > 0) begin
         x = eq.pop_front();
         chk("q", int'(q), int'(x.q));
         chk("busy", int'(busy), int'(x.busy));
         chk("done", int'(done), int'(x.done));
         chk("serout_l", int'(serout_l), int'(x.q[W-1]));
         chk("serout_r", int'(serout_r), int'(x.q[0]));
      end
   end

   initial begin
      rst = 1'b0; en = 1'b0; mode = 3'd0; shiftleft = 1'b0;
      shiftright = 1'b0; parallelin = '0; start = 1'b0; count = '0;
      #1;
      // reset
      cyc(1, 1, 3'd3, 0, 0, 8'hFF, 1, 4'd3);
      // single steps
      cyc(0, 1, 3'd3, 0, 0, 8'hA5, 0, 0);
      cyc(0, 1, 3'd4, 0, 0, 8'h00, 0, 0);
      cyc(0, 1, 3'd5, 0, 0, 8'h00, 0, 0);
      cyc(0, 1, 3'd1, 1, 0, 8'h00, 0, 0);
      cyc(0, 1, 3'd3, 0, 0, 8'h96, 0, 0);
      cyc(0, 1, 3'd6, 0, 0, 8'h00, 0, 0);
      cyc(0, 1, 3'd3, 0, 0, 8'h96, 0, 0);
      cyc(0, 1, 3'd2, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 3'd1, 1, 1, 8'h00, 0, 0);
      cyc(0, 1, 3'd7, 1, 1, 8'h00, 0, 0);
      // burst rotl 3 from 81, start during RUN ignored
      cyc(0, 1, 3'd3, 0, 0, 8'h81, 0, 0);
      cyc(0, 1, 3'd4, 0, 0, 8'h00, 1, 4'd3);
      cyc(0, 1, 3'd3, 1, 1, 8'hFF, 1, 4'd9);
      cyc(0, 1, 3'd1, 1, 1, 8'hFF, 1, 4'd2);
      cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      // back-to-back from DONE: rotr 2
      cyc(0, 0, 3'd5, 0, 0, 8'h00, 1, 4'd2);
      cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      // ignored starts: count=0, mode=load
      cyc(0, 1, 3'd4, 0, 0, 8'h00, 1, 4'd0);
      cyc(0, 1, 3'd3, 0, 0, 8'h3C, 1, 4'd4);
      cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      // reset mid-burst, then normal burst
      cyc(0, 0, 3'd4, 0, 0, 8'h00, 1, 4'd5);
      cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      cyc(1, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 3'd1, 1, 0, 8'h00, 1, 4'd2);
      repeat (4) cyc(0, 0, 3'd0, 1, 0, 8'h00, 0, 0);
      // count > WIDTH
      cyc(0, 0, 3'd6, 0, 0, 8'h00, 1, 4'd15);
      repeat (17) cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) == 0),
             1'($urandom), 3'($urandom),
             1'($urandom), 1'($urandom), W'($urandom),
             ($urandom_range(0, 5) == 0), CW'($urandom));
      end
      cyc(0, 0, 3'd0, 0, 0, 8'h00, 0, 0);
      repeat (2) @(negedge clk);
      chk("queue_drained", eq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/universal_shift_reg_burst.md
Name: universal_shift_reg_burst

Overview:
Parametrised successor to the team's 4-bit universal shift register. WIDTH-bit register with hold, shift, parallel-load, rotate and arithmetic-shift modes, applied one step per enabled cycle. Adds a counted burst mode: one start pulse runs N consecutive shift/rotate steps under busy/done handshake. Used as a general serialiser/deserialiser and bit-manipulation stage.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, 4, width of burst count port; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  single-step enable (ignored while busy)
mode  input  3  operation select (table below)
shiftleft  input  1  serial input entering q[0] on shift-left
shiftright  input  1  serial input entering q[WIDTH-1] on shift-right
parallelin  input  WIDTH  parallel load data
start  input  1  burst request, sampled each edge
count  input  CNT_W  burst step count, sampled with start
q  output  WIDTH  register contents
serout_l  output  1  q[WIDTH-1], combinational
serout_r  output  1  q[0], combinational
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Modes: 000 hold; 001 shl {q[W-2:0],shiftleft}; 010 shr {shiftright,q[W-1:1]}; 011 load parallelin; 100 rotl {q[W-2:0],q[W-1]}; 101 rotr {q[0],q[W-1:1]}; 110 ashr {q[W-1],q[W-1:1]}; 111 reserved, behaves as hold.
- Reset (rst=1 at edge): q=0, busy=0, done=0, FSM->IDLE, latched mode/count cleared. Reset has priority over everything, including mid-burst (burst aborted, no done pulse).
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE: if start=1, count!=0 and mode in {001,010,100,101,110}: latch mode and count into remaining, go RUN, busy=1 from next cycle; q unchanged at this accept edge (start beats en). Otherwise, if en=1, apply mode once; en=0 holds q.
- start with count=0 or mode in {000,011,111}: ignored, treated as no start (en path applies).
- RUN: each edge performs one step of the latched mode, serial inputs sampled live each edge; remaining decrements. Edge on which remaining reaches 0 -> DONE. en, mode, start, count, parallelin ignored in RUN.
- DONE lasts one cycle: done=1, busy=0; then IDLE. Start accepted in DONE (back-to-back bursts).
- Latency: accept edge + N step edges; done high in cycle after Nth step; q then holds N-step result.
- count > WIDTH accepted as-is (rotates wrap; shifts fill fully with serial/sign bits).
- busy is registered: low in IDLE/DONE, high throughout RUN.

Test Plan:
- Reset: rst=1 one edge with arbitrary state -> q=8'h00, busy=0, done=0, serout_l=serout_r=0.
- Single steps (WIDTH=8, en=1): load 8'hA5 -> q=A5; rotl -> 4B; rotr -> A5; shl with shiftleft=1 -> 4B; load 96, ashr -> CB; load 96, shr with shiftright=0 -> 4B; en=0 with mode=001 -> q unchanged.
- Burst: load 8'h81; start=1, count=3, mode=100 -> busy=1 for exactly 3 cycles, q sequence 03,06,0C, done=1 one cycle, final q=8'h0C.
- Ignored starts: start during RUN -> no effect, original burst completes on schedule; start with count=0 or mode=011 -> busy stays 0, no done.
- Back-to-back: start asserted in DONE cycle with count=2, mode=101 -> new burst accepted, busy rises next cycle, second done 3 cycles later.
- Reset mid-burst: count=5 rotl, rst after 2 steps -> q=0, busy=0, no done pulse; next start operates normally.
